// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: pause/nop generation for the 5-stage core
// plus free-running stall and flush event counters.
module hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_pause,
    output logic             if_id_pause,
    output logic             if_id_nop,
    output logic             id_ex_pause,
    output logic             id_ex_nop,
    output logic             ex_mem_pause,
    output logic             mem_wb_nop,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t nxt;

    logic mem_busy;
    logic lu_hazard;
    logic flush_evt;

    assign mem_busy  = dmem_req & ~dmem_ready;
    assign lu_hazard = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    // MEM_WAIT with ready falls through to the RUN decode below,
    // so a branch or hazard deferred by the wait is handled here.
    always_comb begin
        pc_pause     = 1'b0;
        if_id_pause  = 1'b0;
        if_id_nop    = 1'b0;
        id_ex_pause  = 1'b0;
        id_ex_nop    = 1'b0;
        ex_mem_pause = 1'b0;
        mem_wb_nop   = 1'b0;
        flush_evt    = 1'b0;
        nxt          = RUN;
        if (rst) begin
            if (mem_busy) begin
                pc_pause     = 1'b1;
                if_id_pause  = 1'b1;
                id_ex_pause  = 1'b1;
                ex_mem_pause = 1'b1;
                mem_wb_nop   = 1'b1;
                nxt          = MEM_WAIT;
            end else if (branch_taken) begin
                if_id_nop = 1'b1;
                id_ex_nop = 1'b1;
                flush_evt = 1'b1;
            end else if (state == LU_HOLD || lu_hazard) begin
                pc_pause    = 1'b1;
                if_id_pause = 1'b1;
                id_ex_nop   = 1'b1;
                if (state != LU_HOLD && LOAD_USE_STALLS == 2)
                    nxt = LU_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= nxt;
            if (pc_pause)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Generates the pause (hold) and nop (bubble-insert) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use hazards, taken branches/jumps, and data-memory wait states.
- Keeps free-running stall and flush event counters for performance debug.

Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard. 1 = MEM->EX forwarding present; 2 = no forwarding. Only values 1 and 2 are legal.
- CNT_W, 32, width of the event counters.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-low
- id_rs1  input  5  rs1 field of the instruction in ID
- id_rs2  input  5  rs2 field of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  destination register of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- branch_taken  input  1  EX resolved a taken branch or jump
- dmem_req  input  1  MEM stage has an active data-memory access
- dmem_ready  input  1  data memory completes the access this cycle
- pc_pause  output  1  hold PC
- if_id_pause  output  1  hold IF/ID
- if_id_nop  output  1  load nop into IF/ID
- id_ex_pause  output  1  hold ID/EX
- id_ex_nop  output  1  load nop into ID/EX
- ex_mem_pause  output  1  hold EX/MEM
- mem_wb_nop  output  1  load nop into MEM/WB
- stall_cnt  output  CNT_W  cycles with pc_pause=1
- flush_cnt  output  CNT_W  taken-branch flushes applied

Behaviour:
- State register with states RUN, LU_HOLD and MEM_WAIT. All outputs are combinational from state plus inputs, except the counters, which are registered.
- Reset (rst=0, asynchronous): state=RUN, stall_cnt=0, flush_cnt=0. While in reset, all pause/nop outputs are 0.
- Pipeline registers give nop priority over pause. This block never asserts both on one register, except if_id_nop with pc_pause, which is legal.
- Event definitions:
  - mem_busy = dmem_req & ~dmem_ready.
  - lu_hazard = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority per cycle: mem_busy > branch_taken > lu_hazard / LU_HOLD.
- mem_busy, in any state:
  - pc_pause=if_id_pause=id_ex_pause=ex_mem_pause=1 and mem_wb_nop=1; all other nops are 0.
  - Next state = MEM_WAIT.
  - A branch_taken or lu_hazard visible during this cycle is not acted on. EX is frozen, so it is re-presented once memory is ready.
- MEM_WAIT with dmem_ready=1: this cycle is decoded exactly as RUN using the current inputs, including a deferred branch or hazard. The next state comes from that decode.
- branch_taken, not mem_busy:
  - if_id_nop=1 and id_ex_nop=1; no pauses.
  - flush_cnt increments by 1.
  - Next state = RUN; any pending LU_HOLD is cancelled.
- lu_hazard in RUN, not mem_busy, not branch_taken:
  - pc_pause=1, if_id_pause=1, id_ex_nop=1.
  - Next state = LU_HOLD if LOAD_USE_STALLS=2, else RUN.
- LU_HOLD, not mem_busy, not branch_taken:
  - Same outputs as lu_hazard, whatever the current lu_hazard value is (the load has moved on).
  - Next state = RUN.
- Otherwise all pause/nop outputs are 0 and next state = RUN.
- Counters:
  - stall_cnt increments on every cycle with pc_pause=1.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-stall (LU_HOLD or MEM_WAIT): returns to RUN immediately and the counters clear. No residual pause after rst deasserts.
- ex_rd=0 never causes a hazard. ex_rd matching both rs1 and rs2 costs one stall sequence, not two.

Test Plan:
- lw x5 in EX (ex_mem_read=1, ex_rd=5), ID reads id_rs1=5 with id_use_rs1=1, LOAD_USE_STALLS=1 -> one cycle of pc_pause=if_id_pause=id_ex_nop=1, then all 0; stall_cnt=1.
- Same stimulus with LOAD_USE_STALLS=2, EX inputs cleared on cycle 2 -> pause/nop held for exactly 2 cycles; stall_cnt=2. Repeat with ex_rd=0 -> no outputs asserted.
- Load-use hazard and branch_taken in the same cycle -> if_id_nop=id_ex_nop=1, no pauses, flush_cnt=1, stall_cnt=0. Branch_taken in LU_HOLD (LOAD_USE_STALLS=2) -> flush applied and hold cancelled.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> 3 cycles of all four pauses plus mem_wb_nop, then all 0; stall_cnt=3.
- branch_taken held during a 2-cycle memory wait -> no flush during the wait; flush applied on the dmem_ready cycle; flush_cnt=1.
- Assert rst mid-MEM_WAIT -> outputs 0 and counters 0 asynchronously; after release with idle inputs, no pause is asserted.
